// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Game-flow controller for the pong datapath. It sequences
//               IDLE -> SERVE -> PLAY -> OVER, holds the datapath in reset
//               outside PLAY, keeps a packed-BCD hit score and a lives count,
//               switches the puck to fast speed after enough hits, and
//               blinks the score display while the game-over screen is shown.
// Ports       : i_pixel_clk  - sole clock, rising edge
//               i_rst        - asynchronous active-high reset
//               i_nf         - one-cycle new-frame strobe
//               i_start      - debounced start button (level)
//               i_game_over  - miss flag from the datapath (level)
//               i_hit        - one-cycle paddle-contact strobe
//               o_pong_rst   - datapath reset, high in every state but PLAY
//               o_puck_speed - 0 slow, 1 fast
//               o_score      - four-digit packed BCD hit count
//               o_lives      - remaining lives
//               o_state      - IDLE=0, SERVE=1, PLAY=2, OVER=3
//               o_blink      - score blink enable, only active in OVER
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int SERVE_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int LIVES        = 3,
    parameter int HITS_TO_FAST = 8
) (
    input  logic        i_pixel_clk,
    input  logic        i_rst,
    input  logic        i_nf,
    input  logic        i_start,
    input  logic        i_game_over,
    input  logic        i_hit,
    output logic        o_pong_rst,
    output logic        o_puck_speed,
    output logic [15:0] o_score,
    output logic [1:0]  o_lives,
    output logic [1:0]  o_state,
    output logic        o_blink
);

    localparam int C_MAX_FRAMES = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int C_FW         = $clog2(C_MAX_FRAMES + 1);
    localparam int C_HW         = $clog2(HITS_TO_FAST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [C_FW-1:0]   r_frame, w_frame_nxt;
    logic [C_HW-1:0]   r_hits,  w_hits_nxt;
    logic [15:0]       r_score, w_score_nxt;
    logic [1:0]        r_lives, w_lives_nxt;
    logic              r_speed, w_speed_nxt;
    logic              r_blink, w_blink_nxt;
    logic              r_start;
    logic              r_start_armed;
    logic              w_start_evt;

    // Increment packed BCD by one with decimal carry (caller handles 9999).
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (c) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A start event is a rising edge of i_start. After reset the button must
    // first be seen low, so a button held through reset cannot start a game.
    assign w_start_evt = i_start && !r_start && r_start_armed;

    always_ff @(posedge i_pixel_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_frame       <= '0;
            r_hits        <= '0;
            r_score       <= '0;
            r_lives       <= '0;
            r_speed       <= 1'b0;
            r_blink       <= 1'b0;
            r_start       <= 1'b0;
            r_start_armed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame       <= w_frame_nxt;
            r_hits        <= w_hits_nxt;
            r_score       <= w_score_nxt;
            r_lives       <= w_lives_nxt;
            r_speed       <= w_speed_nxt;
            r_blink       <= w_blink_nxt;
            r_start       <= i_start;
            r_start_armed <= r_start_armed | ~i_start;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_hits_nxt  = r_hits;
        w_score_nxt = r_score;
        w_lives_nxt = r_lives;
        // Fast speed latches one cycle after the hit counter saturates and
        // stays set across serves; only a new game start clears it.
        w_speed_nxt = r_speed | (r_hits == C_HW'(HITS_TO_FAST));
        w_blink_nxt = r_blink;

        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_state_nxt = ST_SERVE;
                    w_lives_nxt = 2'(LIVES);
                    w_score_nxt = '0;
                    w_hits_nxt  = '0;
                    w_speed_nxt = 1'b0;
                    w_frame_nxt = '0;
                    w_blink_nxt = 1'b0;
                end
            end
            ST_SERVE: begin
                if (i_nf) begin
                    if (r_frame == C_FW'(SERVE_FRAMES - 1)) begin
                        w_state_nxt = ST_PLAY;
                        w_frame_nxt = '0;
                    end else begin
                        w_frame_nxt = r_frame + C_FW'(1);
                    end
                end
            end
            ST_PLAY: begin
                // A miss outranks a simultaneous hit; the hit is dropped.
                if (i_game_over) begin
                    w_frame_nxt = '0;
                    if (r_lives > 2'd1) begin
                        w_lives_nxt = r_lives - 2'd1;
                        w_state_nxt = ST_SERVE;
                    end else begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = ST_OVER;
                    end
                end else if (i_hit) begin
                    if (r_score != 16'h9999) begin
                        w_score_nxt = bcd_inc(r_score);
                    end
                    if (r_hits != C_HW'(HITS_TO_FAST)) begin
                        w_hits_nxt = r_hits + C_HW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (i_nf) begin
                    if (r_frame == C_FW'(OVER_FRAMES - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_frame_nxt = '0;
                        w_blink_nxt = 1'b0;
                    end else begin
                        w_frame_nxt = r_frame + C_FW'(1);
                        // Counter holds (strobes seen - 1); toggle on every 16th.
                        if ((int'(r_frame) % 16) == 15) begin
                            w_blink_nxt = ~r_blink;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_pong_rst   = (r_state != ST_PLAY);
    assign o_puck_speed = r_speed;
    assign o_score      = r_score;
    assign o_lives      = r_lives;
    assign o_state      = r_state;
    assign o_blink      = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Directed self-checking bench for pong_game_ctrl with default
//               parameters. Walks a full game: start, serve timing, BCD score
//               carry, speed switch, misses, simultaneous hit/miss, game-over
//               blink timing, return to idle, and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    logic        clk;
    logic        rst;
    logic        nf;
    logic        start;
    logic        game_over;
    logic        hit;
    logic        pong_rst;
    logic        puck_speed;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [1:0]  state;
    logic        blink;

    int vectors;
    int miscompares;

    pong_game_ctrl dut (
        .i_pixel_clk (clk),
        .i_rst       (rst),
        .i_nf        (nf),
        .i_start     (start),
        .i_game_over (game_over),
        .i_hit       (hit),
        .o_pong_rst  (pong_rst),
        .o_puck_speed(puck_speed),
        .o_score     (score),
        .o_lives     (lives),
        .o_state     (state),
        .o_blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_nf(input int n);
        for (int i = 0; i < n; i++) begin
            nf = 1'b1;
            tick();
            nf = 1'b0;
        end
    endtask

    task automatic pulse_hit(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
        end
    endtask

    task automatic miss();
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; nf = 1'b0; start = 1'b0; game_over = 1'b0; hit = 1'b0;
        tick();
        chk("rst_state", 16'(state), 16'h0);
        chk("rst_pong_rst", 16'(pong_rst), 16'h1);
        chk("rst_lives", 16'(lives), 16'h0);
        chk("rst_score", score, 16'h0000);
        rst = 1'b0;
        tick();
        chk("idle_wait", 16'(state), 16'h0);

        // Start: rising edge of i_start enters SERVE with a fresh game.
        start = 1'b1;
        tick();
        chk("start_state", 16'(state), 16'h1);
        chk("start_lives", 16'(lives), 16'h3);
        chk("start_score", score, 16'h0000);
        chk("start_pong_rst", 16'(pong_rst), 16'h1);
        tick();
        start = 1'b0;

        // Serve: PLAY exactly on the 120th frame strobe.
        pulse_nf(119);
        chk("serve_119_state", 16'(state), 16'h1);
        chk("serve_119_pong_rst", 16'(pong_rst), 16'h1);
        pulse_nf(1);
        chk("serve_120_state", 16'(state), 16'h2);
        chk("serve_120_pong_rst", 16'(pong_rst), 16'h0);

        // Hits: speed goes fast the cycle after the 8th hit.
        pulse_hit(8);
        chk("hit8_score", score, 16'h0008);
        chk("hit8_speed_lag", 16'(puck_speed), 16'h0);
        tick();
        chk("hit8_speed", 16'(puck_speed), 16'h1);
        pulse_hit(91);
        chk("score_99", score, 16'h0099);
        pulse_hit(1);
        chk("score_100", score, 16'h0100);
        pulse_hit(8);
        chk("score_108", score, 16'h0108);

        // First miss: back to SERVE, speed persists, hits in SERVE ignored.
        miss();
        chk("miss1_state", 16'(state), 16'h1);
        chk("miss1_lives", 16'(lives), 16'h2);
        chk("miss1_speed", 16'(puck_speed), 16'h1);
        pulse_hit(1);
        chk("serve_hit_ignored", score, 16'h0108);
        pulse_nf(120);
        chk("play2_state", 16'(state), 16'h2);
        miss();
        chk("miss2_lives", 16'(lives), 16'h1);
        pulse_nf(120);
        chk("play3_state", 16'(state), 16'h2);

        // Last life: miss and hit together; miss wins, hit dropped.
        game_over = 1'b1;
        hit = 1'b1;
        tick();
        game_over = 1'b0;
        hit = 1'b0;
        chk("over_state", 16'(state), 16'h3);
        chk("over_lives", 16'(lives), 16'h0);
        chk("over_score", score, 16'h0108);

        // Start ignored during OVER.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("over_start_ignored", 16'(state), 16'h3);

        // Game-over blink: toggles at strobes 16, 32, ...; idle after 180.
        pulse_nf(15);
        chk("blink_15", 16'(blink), 16'h0);
        pulse_nf(1);
        chk("blink_16", 16'(blink), 16'h1);
        pulse_nf(15);
        chk("blink_31", 16'(blink), 16'h1);
        pulse_nf(1);
        chk("blink_32", 16'(blink), 16'h0);
        pulse_nf(147);
        chk("blink_179", 16'(blink), 16'h1);
        chk("over_179_state", 16'(state), 16'h3);
        pulse_nf(1);
        chk("over_180_state", 16'(state), 16'h0);
        chk("over_180_blink", 16'(blink), 16'h0);
        chk("idle_score_kept", score, 16'h0108);
        chk("idle_lives_kept", 16'(lives), 16'h0);

        // New game clears score and speed.
        start = 1'b1;
        tick();
        chk("game2_state", 16'(state), 16'h1);
        chk("game2_score", score, 16'h0000);
        chk("game2_speed", 16'(puck_speed), 16'h0);
        chk("game2_lives", 16'(lives), 16'h3);
        pulse_nf(120);
        pulse_hit(3);
        chk("game2_play", 16'(state), 16'h2);

        // Asynchronous reset between edges; start is still held high.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_state", 16'(state), 16'h0);
        chk("arst_pong_rst", 16'(pong_rst), 16'h1);
        chk("arst_score", score, 16'h0000);
        chk("arst_lives", 16'(lives), 16'h0);
        chk("arst_speed", 16'(puck_speed), 16'h0);
        chk("arst_blink", 16'(blink), 16'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("held_start_no_event", 16'(state), 16'h0);
        start = 1'b0;
        tick();
        chk("start_low_idle", 16'(state), 16'h0);
        start = 1'b1;
        tick();
        chk("restart_state", 16'(state), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
